// File: rtl/bus_txn_monitor.sv
// bus_txn_monitor: snoops a bus, filters transactions by address window and keeps a readable history with counters.
module bus_txn_monitor #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32,
    localparam int IW        = $clog2(DEPTH),
    localparam int EW        = 1 + ADDR_WIDTH + 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid_i,
    input  logic                  bus_rw_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_wdata_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic [ADDR_WIDTH-1:0] filt_lo_i,
    input  logic [ADDR_WIDTH-1:0] filt_hi_i,
    input  logic                  mode_i,
    input  logic                  freeze_i,
    input  logic                  clear_i,
    input  logic [IW-1:0]         rd_idx_i,
    output logic [EW-1:0]         rd_entry_o,
    output logic                  rd_valid_o,
    output logic [IW:0]           count_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  activity_o,
    output logic [EW-1:0]         last_o
);
    logic [EW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_addr;
    logic [EW-1:0] txn;
    logic          qual;
    logic          store;
    logic          rd_hit;

    assign txn     = {bus_rw_i, bus_addr_i, bus_rdata_i, bus_wdata_i};
    assign qual    = bus_valid_i & ~freeze_i & (bus_addr_i >= filt_lo_i) & (bus_addr_i <= filt_hi_i);
    assign full_o  = count_o == (IW+1)'(DEPTH);
    assign store   = qual & ~clear_i & (~full_o | ~mode_i);
    assign rd_hit  = {1'b0, rd_idx_i} < count_o;
    assign rd_addr = wr_ptr - IW'(1) - rd_idx_i;

    // History storage; no reset so it maps onto plain RAM, validity comes from count_o
    always_ff @(posedge clk) begin
        if (store && rst_n) mem[wr_ptr] <= txn;
    end

    // Pointer, occupancy, counters, flags and registered readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            count_o    <= '0;
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            overflow_o <= 1'b0;
            activity_o <= 1'b0;
            last_o     <= '0;
            rd_valid_o <= 1'b0;
            rd_entry_o <= '0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            count_o    <= '0;
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            overflow_o <= 1'b0;
            last_o     <= '0;
            rd_valid_o <= 1'b0;
            rd_entry_o <= '0;
        end else begin
            rd_valid_o <= rd_hit;
            rd_entry_o <= rd_hit ? mem[rd_addr] : '0;
            if (qual) begin
                last_o     <= txn;
                activity_o <= ~activity_o;
                if (bus_rw_i) wr_cnt_o <= wr_cnt_o + CNT_WIDTH'(~&wr_cnt_o);
                else          rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(~&rd_cnt_o);
                if (full_o) overflow_o <= 1'b1;
            end
            if (store) begin
                wr_ptr <= wr_ptr + IW'(1);
                if (!full_o) count_o <= count_o + (IW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_bus_txn_monitor.sv
// tb_bus_txn_monitor: scoreboard bench comparing bus_txn_monitor against a queue-based history model.
module tb_bus_txn_monitor;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int D  = 16;
    localparam int EW = 1 + AW + 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_valid, bus_rw, mode, freeze, clear;
    logic [AW-1:0] bus_addr, filt_lo, filt_hi;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [3:0]    rd_idx;
    logic [EW-1:0] rd_entry, last, rd_entry4, last4;
    logic          rd_valid, full, ovf, act, rd_valid4, full4, ovf4, act4;
    logic [4:0]    count, count4;
    logic [31:0]   rd_cnt, wr_cnt;
    logic [3:0]    rd_cnt4, wr_cnt4;

    typedef struct {
        logic [EW-1:0] entry;
        logic          valid;
        int            count;
        longint        rdc, wrc;
        int            rdc4, wrc4;
        logic          full, ovf, act;
        logic [EW-1:0] last;
    } exp_t;

    exp_t          sbq[$];
    logic [EW-1:0] hist[$];
    longint        m_rdc, m_wrc;
    bit            m_ovf, m_act;
    logic [EW-1:0] m_last;
    logic [AW-1:0] g_lo, g_hi;
    bit            g_md;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    bus_txn_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid_i(bus_valid), .bus_rw_i(bus_rw), .bus_addr_i(bus_addr),
        .bus_wdata_i(bus_wdata), .bus_rdata_i(bus_rdata), .filt_lo_i(filt_lo), .filt_hi_i(filt_hi),
        .mode_i(mode), .freeze_i(freeze), .clear_i(clear), .rd_idx_i(rd_idx), .rd_entry_o(rd_entry),
        .rd_valid_o(rd_valid), .count_o(count), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .full_o(full),
        .overflow_o(ovf), .activity_o(act), .last_o(last)
    );

    bus_txn_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus_valid_i(bus_valid), .bus_rw_i(bus_rw), .bus_addr_i(bus_addr),
        .bus_wdata_i(bus_wdata), .bus_rdata_i(bus_rdata), .filt_lo_i(filt_lo), .filt_hi_i(filt_hi),
        .mode_i(mode), .freeze_i(freeze), .clear_i(clear), .rd_idx_i(rd_idx), .rd_entry_o(rd_entry4),
        .rd_valid_o(rd_valid4), .count_o(count4), .rd_cnt_o(rd_cnt4), .wr_cnt_o(wr_cnt4), .full_o(full4),
        .overflow_o(ovf4), .activity_o(act4), .last_o(last4)
    );

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    // Monitor: one expectation per edge, compared just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd_valid", 64'(rd_valid), 64'(e.valid));
            chk("rd_entry", 64'(rd_entry), 64'(e.entry));
            chk("count", 64'(count), 64'(e.count));
            chk("rd_cnt", 64'(rd_cnt), e.rdc);
            chk("wr_cnt", 64'(wr_cnt), e.wrc);
            chk("full", 64'(full), 64'(e.full));
            chk("overflow", 64'(ovf), 64'(e.ovf));
            chk("activity", 64'(act), 64'(e.act));
            chk("last", 64'(last), 64'(e.last));
            chk("rd_cnt_sat4", 64'(rd_cnt4), 64'(e.rdc4));
            chk("wr_cnt_sat4", 64'(wr_cnt4), 64'(e.wrc4));
            chk("count_c4", 64'(count4), 64'(e.count));
            chk("rd_entry_c4", 64'(rd_entry4), 64'(e.entry));
            chk("rd_valid_c4", 64'(rd_valid4), 64'(e.valid));
            chk("last_c4", 64'(last4), 64'(e.last));
            chk("flags_c4", 64'({full4, ovf4, act4}), 64'({e.full, e.ovf, e.act}));
        end
    end

    function automatic exp_t snapshot(input logic [EW-1:0] entry, input logic valid);
        exp_t e;
        e.entry = entry;
        e.valid = valid;
        e.count = hist.size();
        e.rdc   = m_rdc > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_rdc;
        e.wrc   = m_wrc > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_wrc;
        e.rdc4  = m_rdc > 15 ? 15 : int'(m_rdc);
        e.wrc4  = m_wrc > 15 ? 15 : int'(m_wrc);
        e.full  = hist.size() == D;
        e.ovf   = m_ovf;
        e.act   = m_act;
        e.last  = m_last;
        return e;
    endfunction

    // One bus cycle: drive inputs, advance the model, queue the post-edge expectation
    task automatic tx(input bit v, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd, input bit fz, input bit cl, input int idx);
        logic [EW-1:0] t;
        logic [EW-1:0] pre;
        bit            pre_v;
        bit            q;
        @(negedge clk);
        bus_valid = v; bus_rw = rw; bus_addr = a; bus_wdata = wd; bus_rdata = rd;
        filt_lo = g_lo; filt_hi = g_hi; mode = g_md; freeze = fz; clear = cl; rd_idx = 4'(idx);
        t     = {rw, a, rd, wd};
        q     = v && !fz && a >= g_lo && a <= g_hi;
        pre_v = !cl && idx < hist.size();
        pre   = pre_v ? hist[idx] : '0;
        if (cl) begin
            hist.delete(); m_rdc = 0; m_wrc = 0; m_ovf = 0; m_last = '0;
        end else if (q) begin
            m_last = t;
            m_act  = !m_act;
            if (rw) m_wrc++; else m_rdc++;
            if (hist.size() == D) begin
                m_ovf = 1;
                if (!g_md) begin
                    void'(hist.pop_back());
                    hist.push_front(t);
                end
            end else hist.push_front(t);
        end
        sbq.push_back(snapshot(pre, pre_v));
    endtask

    task automatic idle(input int idx);
        tx(0, 0, '0, '0, '0, 0, 0, idx);
    endtask

    // Asynchronous reset asserted between edges, outputs checked before the next edge
    task automatic do_reset();
        @(negedge clk);
        bus_valid = 1'b1;
        rst_n = 1'b0;
        hist.delete(); m_rdc = 0; m_wrc = 0; m_ovf = 0; m_act = 0; m_last = '0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_counters", 64'({rd_cnt, wr_cnt}), 64'd0);
        chk("rst_flags", 64'({rd_valid, full, ovf, act}), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_entry", 64'(rd_entry), 64'd0);
        sbq.push_back(snapshot('0, 1'b0));
        @(negedge clk);
        bus_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; bus_valid = 0; bus_rw = 0; bus_addr = '0; bus_wdata = '0; bus_rdata = '0;
        filt_lo = '0; filt_hi = '0; mode = 0; freeze = 0; clear = 0; rd_idx = '0;
        g_lo = 16'h0000; g_hi = 16'hFFFF; g_md = 0;
        do_reset();
        for (int i = 0; i < 3; i++) tx(1, 1, 16'h10 + 16'(i), 16'hA1 + 16'(i), 16'h5500, 0, 0, 0);
        idle(0); idle(2); idle(3);
        tx(0, 0, '0, '0, '0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tx(1, 1, 16'(i), 16'(i * 3), 16'h0, 0, 0, i % 16);
        idle(0); idle(15); idle(7);
        tx(0, 0, '0, '0, '0, 0, 1, 0);
        g_md = 1;
        for (int i = 0; i < 20; i++) tx(1, 1, 16'(i), 16'(i * 5), 16'h0, 0, 0, 0);
        idle(0); idle(15);
        g_md = 0;
        tx(1, 1, 16'h77, 16'h1, 16'h2, 0, 0, 0);
        idle(0); idle(15);
        tx(0, 0, '0, '0, '0, 0, 1, 0);
        g_lo = 16'h20; g_hi = 16'h2F;
        tx(1, 0, 16'h1F, 16'h0, 16'h11, 0, 0, 0);
        tx(1, 0, 16'h20, 16'h0, 16'h12, 0, 0, 0);
        tx(1, 0, 16'h25, 16'h0, 16'h13, 1, 0, 0);
        tx(1, 0, 16'h2F, 16'h0, 16'h14, 0, 0, 1);
        tx(1, 0, 16'h30, 16'h0, 16'h15, 0, 0, 0);
        idle(0); idle(1); idle(2);
        g_lo = 16'h40; g_hi = 16'h3F;
        tx(1, 1, 16'h40, 16'h9, 16'h9, 0, 0, 0);
        g_lo = 16'h0000; g_hi = 16'hFFFF;
        for (int i = 0; i < 20; i++) tx(1, 0, 16'(i), 16'h0, 16'(i), 0, 0, 0);
        tx(1, 1, 16'h99, 16'h1, 16'h2, 0, 1, 0);
        idle(0);
        for (int i = 0; i < 5; i++) tx(1, 1, 16'h100 + 16'(i), 16'(i), 16'h0, 0, 0, 0);
        do_reset();
        tx(1, 1, 16'hBEEF, 16'h1234, 16'h5678, 0, 0, 0);
        idle(0); idle(1);
        for (int n = 0; n < 3000; n++) begin
            if (n % 97 == 0) begin
                g_lo = 16'($urandom_range(0, 16'h30));
                g_hi = 16'($urandom_range(0, 16'h70));
            end
            if ($urandom_range(0, 99) < 4) g_md = !g_md;
            if ($urandom_range(0, 999) < 4) do_reset();
            tx($urandom_range(0, 99) < 70, 1'($urandom), 16'($urandom_range(0, 16'h7F)),
               16'($urandom), 16'($urandom), $urandom_range(0, 99) < 8,
               $urandom_range(0, 999) < 15, $urandom_range(0, 15));
        end
        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_txn_monitor.md
BUS_TXN_MONITOR -- requirements
Module: bus_txn_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bus read/write data width.
REQ-003 SHALL have parameter DEPTH, default 16, history entries; power of two, >=2; IW = $clog2(DEPTH).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, transaction counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 bus_valid_i  in  1  snooped bus transaction strobe, one cycle per transaction.
REQ-009 bus_rw_i  in  1  1 = write, 0 = read.
REQ-010 bus_addr_i  in  ADDR_WIDTH  transaction address.
REQ-011 bus_wdata_i, bus_rdata_i  in  DATA_WIDTH each  transaction data.
REQ-012 filt_lo_i, filt_hi_i  in  ADDR_WIDTH each  inclusive capture window.
REQ-013 mode_i  in  1  0 = wrap (overwrite oldest), 1 = stop when full.
REQ-014 freeze_i  in  1  suspend all capture and counting.
REQ-015 clear_i  in  1  synchronous clear of history, counters, flags.
REQ-016 rd_idx_i  in  IW  history index, 0 = most recent.
REQ-017 rd_entry_o  out  1+ADDR_WIDTH+2*DATA_WIDTH  {rw, addr, rdata, wdata} of selected entry.
REQ-018 rd_valid_o  out  1  rd_entry_o holds a stored entry.
REQ-019 count_o  out  IW+1  entries held, 0..DEPTH.
REQ-020 rd_cnt_o, wr_cnt_o  out  CNT_WIDTH each  qualifying read/write counts.
REQ-021 full_o  out  1  count_o == DEPTH.
REQ-022 overflow_o  out  1  sticky: a qualifying transaction found history full.
REQ-023 activity_o  out  1  toggles on each qualifying transaction.
REQ-024 last_o  out  1+ADDR_WIDTH+2*DATA_WIDTH  most recent qualifying transaction, same packing.

Function
REQ-025 Qualifying = bus_valid_i & !freeze_i & filt_lo_i <= bus_addr_i <= filt_hi_i (unsigned); filt_lo_i > filt_hi_i SHALL qualify nothing.
REQ-026 Qualifying transaction SHALL update last_o, toggle activity_o, increment wr_cnt_o (rw=1) or rd_cnt_o (rw=0) at the next edge.
REQ-027 Counters SHALL saturate at all-ones, never wrap.
REQ-028 Not full: entry SHALL be written at write pointer; pointer +1 mod DEPTH; count_o +1.
REQ-029 Full, mode_i=0: SHALL overwrite oldest entry, advance pointer, count_o stays DEPTH, set overflow_o.
REQ-030 Full, mode_i=1: SHALL discard entry (pointer, count, history unchanged), set overflow_o; last_o and counters still update.
REQ-031 Readout latency 1 cycle: rd_entry_o/rd_valid_o SHALL reflect rd_idx_i and history as of the previous edge (pre-capture on simultaneous capture).
REQ-032 rd_idx_i >= count_o SHALL give rd_valid_o=0, rd_entry_o=0.
REQ-033 Index mapping: entry = mem[(wr_ptr - 1 - rd_idx_i) mod DEPTH].
REQ-034 clear_i SHALL zero pointer, count_o, counters, overflow_o, last_o, rd_valid_o; activity_o unchanged; memory contents need not clear.
REQ-035 clear_i SHALL win over a simultaneous qualifying transaction (transaction dropped).
REQ-036 mode_i change SHALL take effect next edge, no history loss.

Reset
REQ-037 rst_n low SHALL immediately force all outputs, counters, pointer, count, flags, activity_o to 0.
REQ-038 Reset mid-operation SHALL discard in-flight capture; first qualifying transaction after release SHALL land at index 0 with count_o=1.

Verification
REQ-039 Writes addr 0x10,0x11,0x12 data 0xA1..A3, window 0..0xFFFF -> count_o=3, wr_cnt_o=3, idx0 = {1,0x0012,x,0x00A3} after 1 cycle, idx3 rd_valid_o=0.
REQ-040 DEPTH=16, mode 0, 20 writes addr 0..19 -> count_o=16, full_o=1, overflow_o=1, idx0 addr 19, idx15 addr 4.
REQ-041 Same with mode 1 -> idx0 addr 15, idx15 addr 0, wr_cnt_o=20, last_o addr 19.
REQ-042 Window 0x20..0x2F, reads at 0x1F,0x20,0x2F,0x30 and freeze_i during a 0x25 read -> rd_cnt_o=2, activity_o toggles twice.
REQ-043 CNT_WIDTH=4, 20 reads -> rd_cnt_o=15; clear_i with simultaneous valid write -> all counts 0, count_o=0.
REQ-044 rst_n pulsed low mid-burst -> outputs 0 asynchronously; next write stored at idx0, count_o=1.
